// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-enable divider, h/v counters,
// registered sync/blank/coordinate outputs, line/frame strobes and a frame counter.
module vga_timing_gen #(
    parameter int DIV      = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12,
    parameter int FRAME_W  = 8
) (
    input  logic               clk_50MHz,
    input  logic               reset,
    input  logic               enable,
    input  logic               restart,
    output logic               pix_ce,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [CW-1:0]      x,
    output logic [CW-1:0]      y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]    H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0]    V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0]    HS_LO    = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]    HS_HI    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0]    VS_LO    = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]    VS_HI    = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [CW-1:0]    h;
    logic [CW-1:0]    v;
    logic [CW-1:0]    h_nxt;
    logic [CW-1:0]    v_nxt;
    logic             ce;
    logic             act_nxt;

    function automatic logic in_window(input logic [CW-1:0] pos,
                                       input logic [CW-1:0] lo,
                                       input logic [CW-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    always_comb begin
        ce      = (div == DIV_LAST);
        div_nxt = ce ? '0 : div + DIV_W'(1);
        h_nxt   = (h == H_LAST) ? '0 : h + CW'(1);
        v_nxt   = v;
        if (h == H_LAST) begin
            v_nxt = (v == V_LAST) ? '0 : v + CW'(1);
        end
        act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    end

    // Counters and outputs share one edge so outputs always describe the new (h,v).
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            div         <= '0;
            h           <= H_LAST;
            v           <= V_LAST;
            pix_ce      <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (restart) begin
            // Park at end-of-frame so the next pixel enable opens a fresh frame.
            div         <= '0;
            h           <= H_LAST;
            v           <= V_LAST;
            pix_ce      <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            pix_ce      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            pix_ce      <= ce;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                h           <= h_nxt;
                v           <= v_nxt;
                hs          <= in_window(h_nxt, HS_LO, HS_HI) ? HS_POL : ~HS_POL;
                vs          <= in_window(v_nxt, VS_LO, VS_HI) ? VS_POL : ~VS_POL;
                de          <= act_nxt;
                x           <= act_nxt ? h_nxt : '0;
                y           <= act_nxt ? v_nxt : '0;
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
                if ((h_nxt == '0) && (v_nxt == '0)) begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance, tiny DIV=1 instance and a
// mid-size instance for the restart scenario, all sharing one clock.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic rst_a = 1'b1, en_a = 1'b1, rs_a = 1'b0;
    logic rst_b = 1'b1, en_b = 1'b1, rs_b = 1'b0;
    logic rst_c = 1'b1, en_c = 1'b1, rs_c = 1'b0;

    logic        pix_ce_a, hs_a, vs_a, de_a, line_start_a, frame_start_a;
    logic [11:0] x_a, y_a;
    logic [7:0]  frame_cnt_a;
    logic        pix_ce_b, hs_b, vs_b, de_b, line_start_b, frame_start_b;
    logic [11:0] x_b, y_b;
    logic [7:0]  frame_cnt_b;
    logic        pix_ce_c, hs_c, vs_c, de_c, line_start_c, frame_start_c;
    logic [11:0] x_c, y_c;
    logic [7:0]  frame_cnt_c;

    typedef struct {
        int   x;
        logic hs;
        logic vs;
        logic de;
        logic ls;
    } pix_exp_t;

    typedef struct {
        int cyc;
        int fc;
    } frame_exp_t;

    pix_exp_t   pix_q[$];
    frame_exp_t frame_q[$];
    int         int_q[$];

    vga_timing_gen dut_a (
        .clk_50MHz(clk), .reset(rst_a), .enable(en_a), .restart(rs_a),
        .pix_ce(pix_ce_a), .hs(hs_a), .vs(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .line_start(line_start_a), .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
    );

    vga_timing_gen #(
        .DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_b (
        .clk_50MHz(clk), .reset(rst_b), .enable(en_b), .restart(rs_b),
        .pix_ce(pix_ce_b), .hs(hs_b), .vs(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .line_start(line_start_b), .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
    );

    vga_timing_gen #(
        .DIV(2), .H_ACTIVE(320), .H_FP(8), .H_SYNC(16), .H_BP(16),
        .V_ACTIVE(104), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) dut_c (
        .clk_50MHz(clk), .reset(rst_c), .enable(en_c), .restart(rs_c),
        .pix_ce(pix_ce_c), .hs(hs_c), .vs(vs_c), .de(de_c), .x(x_c), .y(y_c),
        .line_start(line_start_c), .frame_start(frame_start_c), .frame_cnt(frame_cnt_c)
    );

    task automatic test_reset();
        int e;
        repeat (3) @(negedge clk);
        checks++;
        if ({hs_a, vs_a, de_a, pix_ce_a, line_start_a, frame_start_a} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 110000",
                     {hs_a, vs_a, de_a, pix_ce_a, line_start_a, frame_start_a});
        end
        checks++;
        if (x_a !== 12'd0 || y_a !== 12'd0 || frame_cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_xyf: got x=%0d y=%0d fc=%0d required 0/0/0", x_a, y_a, frame_cnt_a);
        end
        int_q.push_back(0);
        int_q.push_back(1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            e = int_q.pop_front();
            checks++;
            if (frame_start_a !== e[0]) begin
                errors++;
                $display("FAIL reset_fs_clk%0d: got %b required %b", k, frame_start_a, e[0]);
            end
        end
        checks++;
        if (x_a !== 12'd0 || y_a !== 12'd0 || de_a !== 1'b1 || line_start_a !== 1'b1 ||
            frame_cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL reset_first_px: got x=%0d y=%0d de=%b ls=%b fc=%0d required 0 0 1 1 1",
                     x_a, y_a, de_a, line_start_a, frame_cnt_a);
        end
    endtask

    task automatic test_line_timing();
        int hs_fall, hs_low, de_cnt, k, e;
        for (int ln = 0; ln < 2; ln++) begin
            int_q.push_back(1312);
            int_q.push_back(192);
            int_q.push_back(1280);
            int_q.push_back(1600);
            hs_fall = -1;
            hs_low  = 0;
            de_cnt  = 0;
            k       = 0;
            do begin
                if (!hs_a) begin
                    if (hs_fall < 0) hs_fall = k;
                    hs_low++;
                end
                if (de_a) de_cnt++;
                @(negedge clk);
                k++;
            end while (!line_start_a && k < 2000);
            e = int_q.pop_front();
            checks++;
            if (hs_fall !== e) begin
                errors++;
                $display("FAIL hs_start_line%0d: got %0d required %0d", ln, hs_fall, e);
            end
            e = int_q.pop_front();
            checks++;
            if (hs_low !== e) begin
                errors++;
                $display("FAIL hs_width_line%0d: got %0d required %0d", ln, hs_low, e);
            end
            e = int_q.pop_front();
            checks++;
            if (de_cnt !== e) begin
                errors++;
                $display("FAIL de_width_line%0d: got %0d required %0d", ln, de_cnt, e);
            end
            e = int_q.pop_front();
            checks++;
            if (k !== e) begin
                errors++;
                $display("FAIL line_period_line%0d: got %0d required %0d", ln, k, e);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [11:0] xh, yh;
        logic        hsh;
        int          k, e;
        repeat (100) @(negedge clk);
        checks++;
        if (x_a !== 12'd50 || y_a !== 12'd2) begin
            errors++;
            $display("FAIL hold_entry_xy: got x=%0d y=%0d required 50 2", x_a, y_a);
        end
        xh  = x_a;
        yh  = y_a;
        hsh = hs_a;
        int_q.push_back(1637);
        en_a = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            checks++;
            if ({x_a, y_a, hs_a, pix_ce_a, line_start_a, frame_start_a} !== {xh, yh, hsh, 3'b000}) begin
                errors++;
                $display("FAIL hold_clk%0d: got x=%0d y=%0d hs=%b ce=%b ls=%b fs=%b required x=%0d y=%0d hs=%b no strobes",
                         i, x_a, y_a, hs_a, pix_ce_a, line_start_a, frame_start_a, xh, yh, hsh);
            end
        end
        en_a = 1'b1;
        k = 137;
        do begin
            @(negedge clk);
            k++;
        end while (!line_start_a && k < 3000);
        e = int_q.pop_front();
        checks++;
        if (k !== e) begin
            errors++;
            $display("FAIL hold_line_delay: got %0d required %0d", k, e);
        end
    endtask

    task automatic test_async_reset();
        repeat (20) @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        checks++;
        if ({hs_a, vs_a, de_a, line_start_a} !== 4'b1100 || x_a !== 12'd0 || y_a !== 12'd0 ||
            frame_cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got hs=%b vs=%b de=%b ls=%b x=%0d y=%0d fc=%0d required 1 1 0 0 0 0 0",
                     hs_a, vs_a, de_a, line_start_a, x_a, y_a, frame_cnt_a);
        end
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic test_div1_raster();
        pix_exp_t e;
        int       k, ln, hh;
        k = 0;
        while (!frame_start_b && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (frame_start_b !== 1'b1) begin
            errors++;
            $display("FAIL div1_sync: got no frame_start in %0d clocks required one", k);
        end
        for (int i = 0; i < 84; i++) begin
            ln   = i / 12;
            hh   = i % 12;
            e.de = (ln < 4) && (hh < 8);
            e.x  = e.de ? hh : 0;
            e.hs = !((hh >= 9) && (hh < 11));
            e.vs = (ln != 5);
            e.ls = (hh == 0);
            pix_q.push_back(e);
        end
        for (int i = 0; i < 84; i++) begin
            e = pix_q.pop_front();
            checks++;
            if (int'(x_b) !== e.x || hs_b !== e.hs || vs_b !== e.vs || de_b !== e.de ||
                line_start_b !== e.ls || pix_ce_b !== 1'b1) begin
                errors++;
                $display("FAIL div1_px%0d: got x=%0d hs=%b vs=%b de=%b ls=%b ce=%b required x=%0d hs=%b vs=%b de=%b ls=%b ce=1",
                         i, x_b, hs_b, vs_b, de_b, line_start_b, pix_ce_b, e.x, e.hs, e.vs, e.de, e.ls);
            end
            @(negedge clk);
        end
        checks++;
        if (frame_start_b !== 1'b1) begin
            errors++;
            $display("FAIL div1_frame_period: got fs=%b at clock 84 required 1", frame_start_b);
        end
    endtask

    task automatic test_frame_wrap();
        frame_exp_t e;
        int         c0, f0, k, prev;
        bit         seen_wrap;
        c0        = cyc;
        f0        = int'(frame_cnt_b);
        prev      = f0;
        seen_wrap = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            e.cyc = c0 + 84 * i;
            e.fc  = (f0 + i) % 256;
            frame_q.push_back(e);
        end
        for (int i = 1; i <= 256; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!frame_start_b && k < 100);
            e = frame_q.pop_front();
            checks++;
            if (cyc !== e.cyc) begin
                errors++;
                $display("FAIL frame_period_%0d: got cycle %0d required %0d", i, cyc, e.cyc);
            end
            checks++;
            if (int'(frame_cnt_b) !== e.fc) begin
                errors++;
                $display("FAIL frame_cnt_%0d: got %0d required %0d", i, frame_cnt_b, e.fc);
            end
            if (prev == 255 && frame_cnt_b == 8'd0) seen_wrap = 1'b1;
            prev = int'(frame_cnt_b);
        end
        checks++;
        if (!seen_wrap) begin
            errors++;
            $display("FAIL frame_cnt_wrap: got no 255->0 step required one");
        end
    endtask

    task automatic test_restart();
        int fc, k, e;
        k = 0;
        while (!(pix_ce_c && de_c && x_c == 12'd300 && y_c == 12'd100) && k < 100000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100000) begin
            errors++;
            $display("FAIL restart_reach: got timeout required x=300 y=100");
            return;
        end
        fc = int'(frame_cnt_c);
        @(negedge clk);
        rs_c = 1'b1;
        @(negedge clk);
        rs_c = 1'b0;
        checks++;
        if ({pix_ce_c, line_start_c, frame_start_c, de_c, hs_c, vs_c} !== 6'b000011 ||
            x_c !== 12'd0 || y_c !== 12'd0 || int'(frame_cnt_c) !== fc) begin
            errors++;
            $display("FAIL restart_edge: got ce=%b ls=%b fs=%b de=%b hs=%b vs=%b x=%0d y=%0d fc=%0d required 0 0 0 0 1 1 0 0 %0d",
                     pix_ce_c, line_start_c, frame_start_c, de_c, hs_c, vs_c, x_c, y_c, frame_cnt_c, fc);
        end
        int_q.push_back(2);
        int_q.push_back((fc + 1) % 256);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start_c && k < 10);
        e = int_q.pop_front();
        checks++;
        if (k !== e) begin
            errors++;
            $display("FAIL restart_fs_delay: got %0d required %0d", k, e);
        end
        e = int_q.pop_front();
        checks++;
        if (int'(frame_cnt_c) !== e || line_start_c !== 1'b1 || de_c !== 1'b1 || x_c !== 12'd0) begin
            errors++;
            $display("FAIL restart_new_frame: got fc=%0d ls=%b de=%b x=%0d required fc=%0d ls=1 de=1 x=0",
                     frame_cnt_c, line_start_c, de_c, x_c, e);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_enable_hold();
        test_async_reset();
        test_div1_raster();
        test_frame_wrap();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
